// File: rtl/ncpu32k_wb_commit_if.sv
// Writeback commit bundle: two in-order result lanes entering the commit
// queue and the two architectural regfile write ports leaving it.
//   master : the execution side plus the regfile (drives lanes, sees ports)
//   slave  : the commit queue (accepts lanes, drives regfile writes)
// Lane 1 is always the older of a same-cycle pair.
interface ncpu32k_wb_commit_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          in_1_valid;
  logic          in_1_ready;
  logic [AW-1:0] in_1_waddr;
  logic [DW-1:0] in_1_wdat;
  logic          in_1_we;
  logic          in_2_valid;
  logic          in_2_ready;
  logic [AW-1:0] in_2_waddr;
  logic [DW-1:0] in_2_wdat;
  logic          in_2_we;
  logic [AW-1:0] arf_1_waddr;
  logic [DW-1:0] arf_1_wdat;
  logic          arf_1_we;
  logic [AW-1:0] arf_2_waddr;
  logic [DW-1:0] arf_2_wdat;
  logic          arf_2_we;

  modport master (
    output in_1_valid, in_1_waddr, in_1_wdat, in_1_we,
    output in_2_valid, in_2_waddr, in_2_wdat, in_2_we,
    input  in_1_ready, in_2_ready,
    input  arf_1_waddr, arf_1_wdat, arf_1_we,
    input  arf_2_waddr, arf_2_wdat, arf_2_we
  );

  modport slave (
    input  in_1_valid, in_1_waddr, in_1_wdat, in_1_we,
    input  in_2_valid, in_2_waddr, in_2_wdat, in_2_we,
    output in_1_ready, in_2_ready,
    output arf_1_waddr, arf_1_wdat, arf_1_we,
    output arf_2_waddr, arf_2_wdat, arf_2_we
  );
endinterface

// File: rtl/ncpu32k_wb_commit.sv
// Writeback commit queue feeding the 2-write-port architectural regfile.
// Buffers up to two in-order results per cycle and retires up to two per
// cycle straight from the head, dropping writes to r0 and the older of two
// same-cycle writes to one register so the regfile never sees a conflict.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : discard every queued entry and this cycle's inputs
//   commit_stall  : hold retirement this cycle
//   wb            : lanes in, regfile write ports out (slave modport)
//   count, empty  : occupancy
module ncpu32k_wb_commit #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   commit_stall,
  ncpu32k_wb_commit_if.slave     wb,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdat;
    logic          we;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic   ready_1, ready_2;
  logic   fire_1, fire_2;
  logic   ret_1, ret_2;
  entry_t e1, e2;
  logic   collide;

  // Readiness uses the registered count only; a same-cycle pop does not
  // free a slot, which keeps ready off the retire path.
  assign ready_1 = ~rst & (count <= CW'(DEPTH - 1));
  assign ready_2 = ~rst & (count <= CW'(DEPTH - 2));

  // Lane 2 only rides along with lane 1, so a lone lane-2 valid is ignored.
  assign fire_1 = wb.in_1_valid & ready_1 & ~flush;
  assign fire_2 = wb.in_2_valid & ready_2 & fire_1;

  assign ret_1 = ~rst & ~commit_stall & ~flush & (count >= CW'(1));
  assign ret_2 = ~rst & ~commit_stall & ~flush & (count >= CW'(2));

  assign e1 = mem[rd_ptr];
  assign e2 = mem[rd_ptr + PW'(1)];

  // The younger write wins when both retiring entries hit one register.
  assign collide = ret_2 & e2.we & (e2.waddr == e1.waddr);

  assign wb.in_1_ready  = ready_1;
  assign wb.in_2_ready  = ready_2;
  assign wb.arf_1_waddr = e1.waddr;
  assign wb.arf_1_wdat  = e1.wdat;
  assign wb.arf_1_we    = ret_1 & e1.we & (e1.waddr != '0) & ~collide;
  assign wb.arf_2_waddr = e2.waddr;
  assign wb.arf_2_wdat  = e2.wdat;
  assign wb.arf_2_we    = ret_2 & e2.we & (e2.waddr != '0);

  assign empty = rst | (count == '0);

  // NOTE: the storage array has no reset; every slot is written before it
  // can be read because count gates retirement, and leaving it unreset
  // lets it map onto plain flops or a small RAM.
  always_ff @(posedge clk) begin
    if (fire_1) mem[wr_ptr]          <= '{wb.in_1_waddr, wb.in_1_wdat, wb.in_1_we};
    if (fire_2) mem[wr_ptr + PW'(1)] <= '{wb.in_2_waddr, wb.in_2_wdat, wb.in_2_we};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(fire_1) + PW'(fire_2);
      rd_ptr <= rd_ptr + PW'(ret_1) + PW'(ret_2);
      count  <= count + CW'(fire_1) + CW'(fire_2) - CW'(ret_1) - CW'(ret_2);
    end
  end

`ifdef NCPU_ENABLE_ASSERT
  always_ff @(posedge clk) begin
    if (!rst) assert (count <= CW'(DEPTH)) else $error("commit queue overflow");
  end
`endif

endmodule
